// File: rtl/pipe_chain_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_chain_pkg: fetch-to-decode link defaults and width helper     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package pipe_chain_pkg;

  localparam int PC_WIDTH = 32;
  localparam int PC_DEPTH = 2;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int clog2w(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_chain_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_stage: one elastic register with valid/ready and flush        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bits
);

  logic             valid;
  logic [WIDTH-1:0] data;

  // Empty or draining this cycle: either way the register may be overwritten.
  assign in_ready  = !valid | out_ready;
  assign out_valid = valid;
  assign out_bits  = data;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (in_ready) begin
      valid <= in_valid;
      if (in_valid) data <= in_bits;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_chain.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pipe_chain: DEPTH elastic stages with flush and occupancy count    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module pipe_chain
  import pipe_chain_pkg::*;
#(
  parameter int WIDTH = PC_WIDTH,
  parameter int DEPTH = PC_DEPTH,
  parameter int CW    = clog2w(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_bits,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits,
  input  logic             io_flush,
  output logic [CW-1:0]    io_count
);

  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] v;
  logic [WIDTH-1:0] d [DEPTH];
  logic             accept_in;
  logic             accept_out;

  assign rdy[DEPTH] = io_out_ready;

  generate
    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic             stage_in_valid;
      logic [WIDTH-1:0] stage_in_bits;

      if (k == 0) begin : g_head
        assign stage_in_valid = io_in_valid & !io_flush;
        assign stage_in_bits  = io_in_bits;
      end else begin : g_body
        assign stage_in_valid = v[k-1];
        assign stage_in_bits  = d[k-1];
      end

      pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clock    (clock),
        .reset    (reset),
        .flush    (io_flush),
        .in_valid (stage_in_valid),
        .in_ready (rdy[k]),
        .in_bits  (stage_in_bits),
        .out_valid(v[k]),
        .out_ready(rdy[k+1]),
        .out_bits (d[k])
      );
    end
  endgenerate

  assign io_in_ready  = rdy[0] & !io_flush;
  assign io_out_valid = v[DEPTH-1] & !io_flush;
  assign io_out_bits  = d[DEPTH-1];

  assign accept_in  = io_in_valid & io_in_ready;
  assign accept_out = io_out_valid & io_out_ready;

  always_ff @(posedge clock) begin
    if (reset || io_flush) begin
      io_count <= '0;
    end else if (accept_in && !accept_out) begin
      io_count <= io_count + CW'(1);
    end else if (!accept_in && accept_out) begin
      io_count <= io_count - CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: doc/pipe_chain.md
Name: pipe_chain

Overview:
- Parametrised chain of DEPTH elastic pipeline stages carrying a WIDTH-bit payload from the fetch side to the decode side.
- Generalises the fixed two-stage pass-through into real registered stages, adding:
  - a valid/ready handshake,
  - back-pressure,
  - a global flush,
  - an occupancy count.
- Sits between stage blocks in the core; for example, with DEPTH=2 it connects instruction fetch to instruction decode.

Parameters:
- WIDTH, 32: payload width in bits; must be 1 or more.
- DEPTH, 2: number of register stages; must be 1 or more.
- CW, clog2(DEPTH+1): width of the occupancy count; this value is derived and must not be overridden.

Ports:
- clock  input  1  single clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- io_in_valid  input  1  upstream presents a payload.
- io_in_ready  output  1  chain accepts a payload this cycle.
- io_in_bits  input  WIDTH  upstream payload.
- io_out_valid  output  1  the last stage holds a payload.
- io_out_ready  input  1  downstream accepts this cycle.
- io_out_bits  output  WIDTH  payload of the last stage.
- io_flush  input  1  kill all in-flight payloads.
- io_count  output  CW  number of valid stages, registered.

Behaviour:
- Stage k (k=0..DEPTH-1) holds a valid bit v[k] and a data register d[k]. Stage 0 is the input end; stage DEPTH-1 drives io_out_*.
- Reset (synchronous, while reset=1 at an edge):
  - all v[k]=0, all d[k]=0, io_count=0.
  - Outputs while reset is held: io_out_valid=0, io_out_bits=0, io_in_ready=1 unless io_flush=1.
- Ready chain (combinational):
  - rdy[DEPTH] = io_out_ready.
  - rdy[k] = !v[k] | rdy[k+1].
  - io_in_ready = rdy[0] & !io_flush.
  - This gives full throughput with no bubble: a full chain whose output drains accepts a new input in the same cycle.
- Transfer at each edge when io_flush=0:
  - Stage 0 loads io_in_bits and sets v[0]=1 if io_in_valid & io_in_ready.
  - Else, if rdy[1], stage 0 sets v[0]=0.
  - Stage k>0 loads d[k-1] and v[k-1] when rdy[k]; otherwise it holds.
  - d[k] changes only when the stage loads a valid payload. Data is not cleared on drain.
- Output:
  - io_out_valid = v[DEPTH-1] & !io_flush.
  - io_out_bits = d[DEPTH-1].
  - No combinational path from io_in_* to io_out_*.
- Latency: a payload accepted at edge t appears on io_out at cycle t+DEPTH-1 after that edge, i.e. it is visible DEPTH cycles after it was presented, when not stalled.
- Stall:
  - With io_out_ready=0 the chain fills; once all v=1, io_in_ready=0.
  - Held payloads and order are preserved.
  - io_out_bits stays stable while io_out_valid=1 and io_out_ready=0.
- Flush:
  - io_flush=1 at an edge clears every v[k] to 0.
  - io_in_ready and io_out_valid are 0 in that cycle, so nothing is accepted or delivered.
  - io_count=0 on the next cycle.
  - Flush held for several cycles keeps the chain empty.
  - Reset has priority over flush.
- Count:
  - io_count(next) = io_count + accept_in - accept_out, where accept_in = io_in_valid & io_in_ready and accept_out = io_out_valid & io_out_ready.
  - Forced to 0 by reset or flush.
  - Simultaneous accept and deliver leaves io_count unchanged.
  - io_count never exceeds DEPTH and never wraps.
- Reset mid-operation: all in-flight payloads are discarded; no partial delivery follows.

Decomposition:
- Shared package holds:
  - the default WIDTH/DEPTH constants for the fetch-to-decode link,
  - a helper function for the clog2 width.
- One natural sub-module: pipe_stage, a single elastic register with in/out valid/ready, data and flush.
  - pipe_chain instantiates it DEPTH times through a generate loop.
  - pipe_chain also owns the count register and the flush gating of io_in_ready and io_out_valid.

Test Plan:
1. Throughput, DEPTH=2, WIDTH=32, io_out_ready=1: drive 0x11,0x22,0x33 on consecutive cycles. Required: io_out_valid rises 2 cycles after the first accept, outputs 0x11,0x22,0x33 back-to-back, io_count steady at 2.
2. Back-pressure: io_out_ready=0, offer 0xA,0xB,0xC. Required: 0xA and 0xB accepted, then io_in_ready=0 with 0xC held, io_count=2, io_out_bits=0xA stable. Release io_out_ready: 0xA,0xB,0xC delivered in order with no bubble.
3. Flush: chain full with 0x5,0x6, assert io_flush for 1 cycle with io_in_valid=1 and data 0x7. Required: io_in_ready=0 and io_out_valid=0 that cycle, io_count=0 next cycle, 0x7 never appears at the output.
4. Simultaneous accept and deliver with the chain full: io_out_ready=1 and io_in_valid=1. Required: io_in_ready=1, io_count stays 2, ordering preserved.
5. Reset mid-stream: assert reset for 1 cycle while 2 payloads are in flight. Required: io_out_valid=0, io_out_bits=0, io_count=0 the next cycle. After reset, a new payload 0x99 appears after exactly DEPTH cycles.
6. Parameter sweep with DEPTH=1, WIDTH=8 and DEPTH=5, WIDTH=64, using random valid/ready. The scoreboard requires:
   - in-order, lossless delivery,
   - io_count equal to the model's count,
   - io_count never greater than DEPTH.
